// File: rtl/modn_pkg.sv
// Shared types and helpers for the round-robin mod-N residue scheduler:
// one-hot FSM states, the round-robin grant search and the one-bit residue step.
package modn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_SHIFT = 3'b010,
    ST_DONE  = 3'b100
  } state_e;

  // First requester with valid set, searching ptr+1, ptr+2, ... modulo nreq.
  function automatic logic [3:0] rr_pick(input logic [15:0] valid,
                                         input logic [3:0]  ptr,
                                         input int          nreq);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i <= nreq && !found) begin
        idx = (int'(ptr) + i) % nreq;
        if (valid[idx[3:0]]) begin
          pick  = idx[3:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  // 2*residue + bit is always below 2*modulus, so one conditional subtract suffices.
  function automatic logic [4:0] mod_step(input logic [4:0] residue,
                                          input logic       bit_in,
                                          input logic [4:0] modulus);
    logic [4:0] sum;
    sum = {residue[3:0], bit_in};
    return (sum >= modulus) ? (sum - modulus) : sum;
  endfunction

endpackage

// File: rtl/modn_serial_sched_if.sv
// Requester and result handshake bundle of the shared mod-N residue scheduler.
interface modn_serial_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int MOD  = 3
) ();
  localparam int IW = $clog2(NREQ);
  localparam int RW = $clog2(MOD);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [IW-1:0]     res_id;
  logic [RW-1:0]     res_residue;
  logic              res_divisible;
  logic              busy;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_residue, res_divisible, busy
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_residue, res_divisible, busy
  );
endinterface

// File: rtl/modn_residue_core.sv
// Serial MSB-first residue accumulator: each enabled cycle folds one bit into
// residue = (2*residue + bit) mod MOD.
module modn_residue_core
  import modn_pkg::*;
#(
  parameter  int MOD = 3,
  localparam int RW  = $clog2(MOD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          bit_in,
  output logic [RW-1:0] residue
);

  logic [RW-1:0] residue_q, residue_d;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal
    // unassigned; otherwise synthesis infers a latch.
    residue_d = residue_q;
    if (clr) begin
      residue_d = '0;
    end else if (en) begin
      residue_d = RW'(mod_step(5'(residue_q), bit_in, 5'(MOD)));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) residue_q <= '0;
    else        residue_q <= residue_d;
  end

  assign residue = residue_q;

endmodule

// File: rtl/modn_serial_sched.sv
// Round-robin arbiter sharing one serial mod-N residue engine between NREQ
// requesters; results return with the requester id through a valid/ready port.
module modn_serial_sched
  import modn_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int MOD  = 3
) (
  input logic               clk,
  input logic               rst_n,
  modn_serial_sched_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int RW = $clog2(MOD);
  localparam int CW = $clog2(W + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   grant;
  logic [NREQ-1:0] req_ready;
  logic            core_clr, core_en;
  logic [RW-1:0]   residue;
  logic            res_valid;

  assign grant = IW'(rr_pick(16'(bus.req_valid), 4'(rr_ptr_q), NREQ));

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    core_clr  = 1'b0;
    core_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          req_ready = NREQ'(1) << grant;
          shreg_d   = bus.req_data[grant*W +: W];
          id_d      = grant;
          rr_ptr_d  = grant;
          cnt_d     = CW'(W);
          core_clr  = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        core_en = 1'b1;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= IW'(NREQ - 1);
      id_q     <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
    end
  end

  modn_residue_core #(.MOD(MOD)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (core_clr),
    .en     (core_en),
    .bit_in (shreg_q[W-1]),
    .residue(residue)
  );

  // Results are exposed only from DONE so intermediate SHIFT residues never leak.
  assign res_valid         = (state_q == ST_DONE);
  assign bus.res_valid     = res_valid;
  assign bus.res_id        = res_valid ? id_q : '0;
  assign bus.res_residue   = res_valid ? residue : '0;
  assign bus.res_divisible = res_valid && (residue == '0);
  assign bus.busy          = (state_q != ST_IDLE);
  // Grants are suppressed while reset is held even though the FSM sits in IDLE.
  assign bus.req_ready     = rst_n ? req_ready : '0;

endmodule

// File: tb/tb_modn_serial_sched.sv
// Directed bench for modn_serial_sched: default 4x8-bit mod-3 instance plus a
// 2x4-bit mod-5 variant sharing clock and reset.
module tb_modn_serial_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   prev_acc = 0;
  int   last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  modn_serial_sched_if #(.NREQ(4), .W(8), .MOD(3)) bus_a ();
  modn_serial_sched_if #(.NREQ(2), .W(4), .MOD(5)) bus_b ();

  modn_serial_sched #(.NREQ(4), .W(8), .MOD(3)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  modn_serial_sched #(.NREQ(2), .W(4), .MOD(5)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int i, input logic [7:0] d);
    bus_a.req_data[i*8 +: 8] = d;
    bus_a.req_valid[i]       = 1'b1;
  endtask

  task automatic set_b(input int i, input logic [3:0] d);
    bus_b.req_data[i*4 +: 4] = d;
    bus_b.req_valid[i]       = 1'b1;
  endtask

  task automatic check_a_idle_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus_a.req_ready), 32'd0);
    check({tag, "_res_valid"}, 32'(bus_a.res_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus_a.busy), 32'd0);
    check({tag, "_res_id"}, 32'(bus_a.res_id), 32'd0);
    check({tag, "_residue"}, 32'(bus_a.res_residue), 32'd0);
    check({tag, "_divisible"}, 32'(bus_a.res_divisible), 32'd0);
  endtask

  // Accept on the next edge, then expect the result exactly 8 cycles later.
  task automatic serve_a(input int id, input int exp_res);
    #1;
    check("a_grant", 32'(bus_a.req_ready), 32'(1) << id);
    step();
    prev_acc = last_acc;
    last_acc = cyc;
    bus_a.req_valid[id] = 1'b0;
    check("a_ready_in_shift", 32'(bus_a.req_ready), 32'd0);
    check("a_busy_in_shift", 32'(bus_a.busy), 32'd1);
    repeat (7) step();
    check("a_valid_early", 32'(bus_a.res_valid), 32'd0);
    step();
    check("a_valid", 32'(bus_a.res_valid), 32'd1);
    check("a_id", 32'(bus_a.res_id), 32'(id));
    check("a_residue", 32'(bus_a.res_residue), 32'(exp_res));
    check("a_divisible", 32'(bus_a.res_divisible), 32'(exp_res == 0));
    bus_a.res_ready = 1'b1;
    step();
    bus_a.res_ready = 1'b0;
    check("a_valid_drop", 32'(bus_a.res_valid), 32'd0);
    check("a_busy_idle", 32'(bus_a.busy), 32'd0);
  endtask

  task automatic serve_b(input int id, input int exp_res);
    #1;
    check("b_grant", 32'(bus_b.req_ready), 32'(1) << id);
    step();
    bus_b.req_valid[id] = 1'b0;
    repeat (3) step();
    check("b_valid_early", 32'(bus_b.res_valid), 32'd0);
    step();
    check("b_valid", 32'(bus_b.res_valid), 32'd1);
    check("b_id", 32'(bus_b.res_id), 32'(id));
    check("b_residue", 32'(bus_b.res_residue), 32'(exp_res));
    check("b_divisible", 32'(bus_b.res_divisible), 32'(exp_res == 0));
    bus_b.res_ready = 1'b1;
    step();
    bus_b.res_ready = 1'b0;
    check("b_valid_drop", 32'(bus_b.res_valid), 32'd0);
  endtask

  initial begin
    int sw_d [6] = '{9, 10, 254, 255, 0, 1};
    int sw_r [6] = '{0, 1, 2, 0, 0, 1};

    rst_n           = 1'b0;
    bus_a.req_valid = '0;
    bus_a.req_data  = '0;
    bus_a.res_ready = 1'b0;
    bus_b.req_valid = '0;
    bus_b.req_data  = '0;
    bus_b.res_ready = 1'b0;

    // Contention set up during reset: grants must stay low until release.
    set_a(0, 8'd3);
    set_a(1, 8'd4);
    set_a(2, 8'd5);
    set_a(3, 8'd6);
    repeat (2) step();
    check_a_idle_outputs("reset");
    check("reset_b_busy", 32'(bus_b.busy), 32'd0);
    rst_n = 1'b1;

    serve_a(0, 0);
    serve_a(1, 1);
    check("spacing_1", 32'(last_acc - prev_acc), 32'd10);
    serve_a(2, 2);
    check("spacing_2", 32'(last_acc - prev_acc), 32'd10);
    serve_a(3, 0);
    check("spacing_3", 32'(last_acc - prev_acc), 32'd10);

    // Re-assert req0 and req2 after the pointer has wrapped to 3.
    set_a(0, 8'd7);
    set_a(2, 8'd8);
    serve_a(0, 1);
    serve_a(2, 2);
    check("spacing_4", 32'(last_acc - prev_acc), 32'd10);

    for (int i = 0; i < 6; i++) begin
      set_a(0, 8'(sw_d[i]));
      serve_a(0, sw_r[i]);
    end

    // Backpressure: result held for 5 cycles while another request waits.
    set_a(0, 8'd11);
    #1;
    check("bp_grant", 32'(bus_a.req_ready), 32'd1);
    step();
    bus_a.req_valid[0] = 1'b0;
    repeat (8) step();
    set_a(1, 8'd12);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus_a.res_valid), 32'd1);
      check("bp_id", 32'(bus_a.res_id), 32'd0);
      check("bp_residue", 32'(bus_a.res_residue), 32'd2);
      check("bp_divisible", 32'(bus_a.res_divisible), 32'd0);
      check("bp_ready_low", 32'(bus_a.req_ready), 32'd0);
      step();
    end
    bus_a.res_ready = 1'b1;
    step();
    bus_a.res_ready = 1'b0;
    serve_a(1, 0);

    // Reset three cycles into SHIFT of a req2 word; the pointer must return to 3.
    set_a(2, 8'd5);
    #1;
    check("rst_grant", 32'(bus_a.req_ready), 32'd4);
    step();
    bus_a.req_valid[2] = 1'b0;
    repeat (3) step();
    set_a(1, 8'd100);
    set_a(3, 8'd200);
    rst_n = 1'b0;
    #1;
    check_a_idle_outputs("midshift_rst");
    step();
    step();
    rst_n = 1'b1;
    serve_a(1, 1);
    serve_a(3, 2);

    // Variant instance: NREQ=2, W=4, MOD=5.
    set_b(0, 4'd15);
    serve_b(0, 0);
    set_b(1, 4'd14);
    serve_b(1, 4);
    set_b(0, 4'd7);
    serve_b(0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/modn_serial_sched.md
Name: modn_serial_sched

Overview:
- Round-robin scheduler that shares one serial mod-N residue engine between NREQ requesters.
- Each requester submits a W-bit word through a valid/ready handshake.
- The block serializes the word MSB-first through the residue FSM, then returns the residue, a divisible flag and the requester id through a valid/ready result port.
- Sits in front of the divisibility-check datapath so several producers can use one checker.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 8, word width in bits (1..32).
- MOD, 3, divisor (2..15).
- IW, $clog2(NREQ), requester id width (localparam).
- RW, $clog2(MOD), residue width (localparam).
- CW, $clog2(W+1), bit-counter width (localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*W  packed words; requester i uses bits [i*W +: W].
- req_ready  out  NREQ  one-hot accept; at most one bit high.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_id  out  IW  index of the requester whose word produced the result.
- res_residue  out  RW  word mod MOD.
- res_divisible  out  1  1 iff res_residue == 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=NREQ-1, so requester 0 has highest priority first.
  - residue=0, bit counter=0, shift register=0.
  - res_valid=0, res_id=0, res_residue=0, res_divisible=0, busy=0, req_ready=0.
- States: IDLE, SHIFT, DONE, one-hot encoded. Illegal encodings go to IDLE.
- IDLE:
  - Grant = first requester with req_valid high, searching rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - req_ready[grant]=1 combinationally, only in IDLE and only when some req_valid is high.
  - On that edge: latch req_data[grant] into the shift register, id=grant, rr_ptr=grant, residue=0, counter=W. Next state is SHIFT.
  - With no request, stay in IDLE.
- SHIFT:
  - Each cycle: bit = shreg[W-1]; residue <= (2*residue + bit) mod MOD; shreg <<= 1; counter -= 1.
  - When counter reaches 1, that edge processes the final bit and the next state is DONE.
  - Exactly W SHIFT cycles.
- Mod arithmetic:
  - 2*residue+bit < 2*MOD, so compute it as a single conditional subtract of MOD.
  - No divider. Intermediate width RW+1.
- DONE:
  - res_valid=1; res_id, res_residue and res_divisible are registered and held stable until res_valid && res_ready.
  - On the handshake edge, next state is IDLE and res_valid drops the next cycle.
- Latency and throughput:
  - res_valid rises exactly W cycles after the accept edge (first visible in cycle accept+W+1).
  - Minimum spacing between accepts is W+2 cycles.
- req_ready is 0 in SHIFT and DONE. Requesters must hold req_valid and req_data stable until accepted.
- Simultaneous requests: exactly one grant per accept. A requester holding req_valid high is served within NREQ accepts.
- A req_valid deasserted before accept is simply not granted; no state change.
- res_ready is ignored when res_valid=0.
- Reset mid-SHIFT or mid-DONE: the in-flight word is discarded with no result and rr_ptr returns to NREQ-1.
- The residue engine is a Moore FSM on the residue register; the output is taken only from DONE, never from intermediate SHIFT states.

Decomposition:
- Shared package modn_pkg holds:
  - state typedef (IDLE/SHIFT/DONE one-hot constants);
  - function rr_pick(valid, ptr) returning the next grant index;
  - function mod_step(residue, bit, MOD).
- One natural sub-module: modn_residue_core.
  - Ports: clk, rst_n, clr, en, bit_in, residue.
  - Owns the residue register and mod_step.
  - The scheduler owns arbitration, the shift register, the counter and the result registers.

Test Plan:
- Single requester, W=8, MOD=3: req0 data 8'd9 → req_ready[0] for 1 cycle; res_valid 8 cycles later; res_id=0, res_residue=0, res_divisible=1.
- Residue sweep: 8'd10→1, 8'd254→2, 8'd255→0 (divisible=1), 8'd0→0 (divisible=1), 8'd1→1. Compare every result against a scoreboard computing data%3.
- Contention: all four req_valid high from reset with data 3,4,5,6 → grants in order 0,1,2,3, residues 0,1,2,0. Then req0 and req2 re-assert → grants 0 then 2. Accept spacing is exactly 10 cycles with res_ready=1.
- Backpressure: hold res_ready low for 5 cycles in DONE → res_valid and result fields stable, req_ready stays 0 even with req_valid high; accept happens on the cycle after the handshake.
- Reset mid-SHIFT: assert rst_n=0 after 3 shift cycles → all outputs 0 immediately. After release with req1 and req3 valid, req1 is granted first and its result is correct.
- Parameter variant NREQ=2, W=4, MOD=5: data 4'd15→0/divisible, 4'd14→4, 4'd7→2. res_valid rises 4 cycles after accept.
